// File: rtl/seq_job_arbiter.sv
// Round-robin owner of one shared RA/RB/TM sequencer: grants a pending job,
// pulses START/JP, waits for the TM phase, returns DONE, flags stuck sequencers.
module seq_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [N_REQ-1:0]         REQ_JP,
    input  logic                     SEQ_TM,
    output logic                     START,
    output logic                     JP,
    output logic [N_REQ-1:0]         GNT,
    output logic [$clog2(N_REQ)-1:0] GNT_ID,
    output logic [N_REQ-1:0]         DONE,
    output logic                     ERR,
    output logic [$clog2(N_REQ)-1:0] ERR_ID,
    input  logic                     ERR_CLR
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_TM,
        ST_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] err_id_q, err_id_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          jp_q, jp_d;
    logic          err_q, err_d;

    logic          pick_found;
    logic [IW-1:0] pick_id;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int step);
        return IW'((int'(base) + step) % N_REQ);
    endfunction

    // First requester at or after the pointer, wrapping around.
    always_comb begin : rr_pick
        pick_found = 1'b0;
        pick_id    = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && REQ[wrap_add(ptr_q, i)]) begin
                pick_found = 1'b1;
                pick_id    = wrap_add(ptr_q, i);
            end
        end
    end

    // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin : next_state
        state_d  = state_q;
        owner_d  = owner_q;
        jp_d     = jp_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        err_d    = err_q & ~ERR_CLR;
        err_id_d = err_id_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_id;
                    jp_d    = REQ_JP[pick_id];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT_TM;
            end
            ST_WAIT_TM: begin
                timer_d = timer_q + TW'(1);
                if (SEQ_TM) begin
                    state_d = ST_RELEASE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // A timeout outranks a same-cycle ERR_CLR.
                    err_d    = 1'b1;
                    err_id_d = owner_q;
                    ptr_d    = wrap_add(owner_q, 1);
                    state_d  = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                ptr_d   = wrap_add(owner_q, 1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            jp_q     <= 1'b0;
            ptr_q    <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            jp_q     <= jp_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    // Outputs decode flops only; REQ never reaches them combinationally.
    always_comb begin : outputs
        START  = (state_q == ST_ISSUE);
        JP     = (state_q == ST_ISSUE) & jp_q;
        GNT    = '0;
        DONE   = '0;
        GNT_ID = '0;
        if (state_q != ST_IDLE) begin
            GNT[owner_q] = 1'b1;
            GNT_ID       = owner_q;
        end
        if (state_q == ST_RELEASE) begin
            DONE[owner_q] = 1'b1;
        end
        ERR    = err_q;
        ERR_ID = err_id_q;
    end

endmodule

// File: tb/tb_seq_job_arbiter.sv
// Bench for seq_job_arbiter: behavioural sequencer, round-robin reference model,
// expectation queue filled by stimulus and drained by an independent monitor.
module tb_seq_job_arbiter;
    localparam int N       = 4;
    localparam int IW      = $clog2(N);
    localparam int TIMEOUT = 15;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [N-1:0]  REQ;
    logic [N-1:0]  REQ_JP;
    logic          SEQ_TM;
    logic          START;
    logic          JP;
    logic [N-1:0]  GNT;
    logic [IW-1:0] GNT_ID;
    logic [N-1:0]  DONE;
    logic          ERR;
    logic [IW-1:0] ERR_ID;
    logic          ERR_CLR;

    seq_job_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_JP(REQ_JP), .SEQ_TM(SEQ_TM),
        .START(START), .JP(JP), .GNT(GNT), .GNT_ID(GNT_ID), .DONE(DONE),
        .ERR(ERR), .ERR_ID(ERR_ID), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    // Behavioural sequencer: S0 -START-> S1 -> (JP ? S3 : S2 -> S3) -> S0, TM in S3.
    int   seq_st;
    logic seq_jp;
    logic stall;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            seq_st <= 0;
            seq_jp <= 1'b0;
        end else begin
            case (seq_st)
                0: if (START) begin seq_st <= 1; seq_jp <= JP; end
                1: seq_st <= seq_jp ? 3 : 2;
                2: seq_st <= 3;
                default: seq_st <= 0;
            endcase
        end
    end
    assign SEQ_TM = (seq_st == 3) && !stall;

    typedef struct {
        int id;
        bit jp;
        bit tmo;
    } exp_t;

    exp_t         exp_q[$];
    int           n_vec     = 0;
    int           n_err     = 0;
    int           start_cnt = 0;
    int           end_cnt   = 0;
    int           m_ptr     = 0;
    logic [N-1:0] s_req[$];
    logic [N-1:0] s_jp[$];
    bit           s_stall[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic push_job(input logic [N-1:0] req, input logic [N-1:0] jpv, input bit stl);
        exp_t e;
        e.id  = rr_pick(m_ptr, req);
        e.jp  = jpv[e.id];
        e.tmo = stl;
        exp_q.push_back(e);
        m_ptr  = (e.id + 1) % N;
        REQ    = req;
        REQ_JP = jpv;
    endtask

    task automatic set_job(input logic [N-1:0] req, input logic [N-1:0] jpv, input bit stl);
        s_req.push_back(req);
        s_jp.push_back(jpv);
        s_stall.push_back(stl);
    endtask

    // Each next job is presented while the current one is in flight, so a
    // request change after grant is exercised on every back-to-back job.
    task automatic run_stream();
        int n, base_s, base_d, guard;
        n      = s_req.size();
        base_s = start_cnt;
        base_d = end_cnt;
        @(negedge CLK);
        push_job(s_req[0], s_jp[0], s_stall[0]);
        for (int e = 0; e < n; e++) begin
            guard = 0;
            while (start_cnt <= base_s + e && guard < 80) begin
                @(negedge CLK);
                guard++;
            end
            check("job_started", 32'(start_cnt > base_s + e), 32'd1);
            if (start_cnt <= base_s + e) begin
                exp_q.delete();
                break;
            end
            if (e + 1 < n) push_job(s_req[e+1], s_jp[e+1], s_stall[e+1]);
            else begin REQ = '0; REQ_JP = '0; end
        end
        guard = 0;
        while (end_cnt < base_d + n && guard < 80) begin
            @(negedge CLK);
            guard++;
        end
        check("jobs_finished", 32'(end_cnt >= base_d + n), 32'd1);
        REQ    = '0;
        REQ_JP = '0;
        s_req.delete();
        s_jp.delete();
        s_stall.delete();
    endtask

    task automatic wait_start();
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!START && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        check("start_seen", 32'(START), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},  32'(START),  32'd0);
        check({tag, "_jp"},     32'(JP),     32'd0);
        check({tag, "_gnt"},    32'(GNT),    32'd0);
        check({tag, "_gnt_id"}, 32'(GNT_ID), 32'd0);
        check({tag, "_done"},   32'(DONE),   32'd0);
        check({tag, "_err"},    32'(ERR),    32'd0);
        check({tag, "_err_id"}, 32'(ERR_ID), 32'd0);
    endtask

    // Monitor: pops one expectation per START and follows that job to its end.
    initial begin : monitor
        exp_t         cur;
        int           age, lat;
        logic [N-1:0] oh;
        bit           busy;
        busy  = 0;
        stall = 1'b0;
        age   = 0;
        lat   = 0;
        oh    = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                busy = 0;
                continue;
            end
            if (!busy) begin
                if (START) begin
                    start_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 32'(START), 32'd0);
                    end else begin
                        cur   = exp_q.pop_front();
                        oh    = onehot(cur.id);
                        stall = cur.tmo;
                        busy  = 1;
                        age   = 0;
                        lat   = cur.tmo ? TIMEOUT + 1 : (cur.jp ? 3 : 4);
                        check("start_gnt",    32'(GNT),    32'(oh));
                        check("start_gnt_id", 32'(GNT_ID), 32'(cur.id));
                        check("start_jp",     32'(JP),     32'(cur.jp));
                        check("start_done",   32'(DONE),   32'd0);
                    end
                end else begin
                    check("idle_gnt",  32'(GNT),  32'd0);
                    check("idle_done", 32'(DONE), 32'd0);
                end
            end else begin
                age++;
                check("busy_start", 32'(START), 32'd0);
                if (age < lat) begin
                    check("hold_gnt",   32'(GNT),  32'(oh));
                    check("early_done", 32'(DONE), 32'd0);
                end else if (cur.tmo) begin
                    check("tmo_err",    32'(ERR),    32'd1);
                    check("tmo_err_id", 32'(ERR_ID), 32'(cur.id));
                    check("tmo_gnt",    32'(GNT),    32'd0);
                    check("tmo_done",   32'(DONE),   32'd0);
                    busy = 0;
                    end_cnt++;
                end else begin
                    check("done",        32'(DONE), 32'(oh));
                    check("release_gnt", 32'(GNT),  32'(oh));
                    busy = 0;
                    end_cnt++;
                end
            end
        end
    end

    initial begin : stimulus
        RESET   = 1'b1;
        REQ     = '0;
        REQ_JP  = '0;
        ERR_CLR = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        // All requesters held high from PTR=0: grants 0,1,2,3,0.
        for (int i = 0; i < 5; i++) set_job(4'b1111, 4'b0000, 1'b0);
        run_stream();

        // Single requester, long path (DONE four cycles after START).
        set_job(4'b0100, 4'b0000, 1'b0);
        run_stream();
        check("t1_err", 32'(ERR), 32'd0);

        // Jump option: short path (DONE three cycles after START).
        set_job(4'b0010, 4'b0010, 1'b0);
        run_stream();

        // Sequencer never reaches TM: timeout on owner 3, then clear.
        set_job(4'b1000, 4'b0000, 1'b1);
        run_stream();
        check("t4_err_set", 32'(ERR), 32'd1);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("t4_err_clr",    32'(ERR),    32'd0);
        check("t4_err_id_kept", 32'(ERR_ID), 32'd3);

        // Clear requested in the very cycle the timeout fires.
        @(negedge CLK);
        push_job(4'b0010, 4'b0000, 1'b1);
        wait_start();
        REQ = '0;
        repeat (TIMEOUT) @(negedge CLK);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        check("t6_err",    32'(ERR),    32'd1);
        check("t6_err_id", 32'(ERR_ID), 32'd1);

        // Asynchronous reset in the middle of WAIT_TM.
        push_job(4'b0010, 4'b0000, 1'b0);
        wait_start();
        REQ = '0;
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1 check_all_zero("async_reset");
        m_ptr = 0;
        exp_q.delete();
        @(negedge CLK);
        #2 RESET = 1'b0;
        set_job(4'b1001, 4'b0000, 1'b0);
        run_stream();

        // Randomized back-to-back jobs with occasional stuck sequencer.
        for (int i = 0; i < 30; i++)
            set_job(N'($urandom_range(1, (1 << N) - 1)), N'($urandom),
                    ($urandom_range(0, 7) == 0));
        run_stream();

        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
